// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_capture_pkg : capture FSM states and signed trigger-crossing helper
// Rev 1.0
// ---------------------------------------------------------------------------
package adc_capture_pkg;

   localparam int c_data_width = 14;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRE       = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   // Arguments are sign-extended samples so any sample width up to 32 fits.
   function automatic logic trig_cond(input logic signed [31:0] prev,
                                      input logic signed [31:0] cur,
                                      input logic signed [31:0] level,
                                      input logic               falling);
      logic hit;
      if (falling) hit = (prev > level) && (cur <= level);
      else         hit = (prev < level) && (cur >= level);
      return hit;
   endfunction

endpackage
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// capture_ram : simple dual-port sample buffer, 1-cycle registered read
// Rev 1.0
// ---------------------------------------------------------------------------
module capture_ram #(
   parameter int DATA_WIDTH = 14,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   localparam int c_depth = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [c_depth];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Read data only moves on re_i so a stalled reader sees a stable word.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/adc_stream_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_stream_capture : triggered circular-buffer capture with ordered replay
// Rev 1.0
// ---------------------------------------------------------------------------
module adc_stream_capture
   import adc_capture_pkg::*;
#(
   parameter int DATA_WIDTH = c_data_width,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  data_en_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  arm_i,
   input  logic                  sw_trig_i,
   input  logic [DATA_WIDTH-1:0] trig_level_i,
   input  logic                  trig_edge_i,
   input  logic [DEPTH_LOG2-1:0] pretrig_i,
   output logic                  busy_o,
   output logic                  triggered_o,
   output logic                  done_o,
   output logic [DEPTH_LOG2-1:0] trig_addr_o,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_last_o
);
   localparam int                    c_depth     = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] c_pre_full  = DEPTH_LOG2'(c_depth - 1);
   localparam logic [DEPTH_LOG2-1:0] c_post_span = DEPTH_LOG2'(c_depth - 2);
   localparam logic [DEPTH_LOG2:0]   c_rd_last   = (DEPTH_LOG2 + 1)'(c_depth - 1);
   localparam logic [DEPTH_LOG2:0]   c_rd_all    = (DEPTH_LOG2 + 1)'(c_depth);

   state_e                  state_q, state_d;
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]   pretrig_q, pretrig_d;
   logic [DATA_WIDTH-1:0]   level_q, level_d;
   logic                    falling_q, falling_d;
   logic [DATA_WIDTH-1:0]   prev_q, prev_d;
   logic                    prev_vld_q, prev_vld_d;
   logic                    sw_pend_q, sw_pend_d;
   logic [DEPTH_LOG2-1:0]   trig_addr_q, trig_addr_d;
   logic                    triggered_q, triggered_d;
   logic [DEPTH_LOG2-1:0]   rd_addr_q, rd_addr_d;
   logic [DEPTH_LOG2:0]     rd_cnt_q, rd_cnt_d;
   logic                    rd_valid_q, rd_valid_d;
   logic                    rd_last_q, rd_last_d;

   logic                    ram_we, ram_re, rd_fire, edge_hit;
   logic [DATA_WIDTH-1:0]   ram_rdata;

   assign rd_fire  = rd_valid_q & rd_ready_i;
   assign edge_hit = prev_vld_q & trig_cond(32'($signed(prev_q)), 32'($signed(data_i)),
                                            32'($signed(level_q)), falling_q);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q;
      pretrig_d   = pretrig_q;
      level_d     = level_q;
      falling_d   = falling_q;
      prev_d      = prev_q;
      prev_vld_d  = prev_vld_q;
      sw_pend_d   = sw_pend_q;
      trig_addr_d = trig_addr_q;
      triggered_d = triggered_q;
      rd_addr_d   = rd_addr_q;
      rd_cnt_d    = rd_cnt_q;
      rd_valid_d  = rd_valid_q;
      rd_last_d   = rd_last_q;
      ram_we      = 1'b0;
      ram_re      = 1'b0;

      if ((state_q == ST_PRE || state_q == ST_WAIT_TRIG || state_q == ST_POST) && data_en_i) begin
         ram_we     = 1'b1;
         wr_ptr_d   = wr_ptr_q + 1'b1;
         prev_d     = data_i;
         prev_vld_d = 1'b1;
      end

      case (state_q)
         ST_PRE: begin
            if (data_en_i) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == pretrig_q - 1'b1) state_d = ST_WAIT_TRIG;
            end
         end
         ST_WAIT_TRIG: begin
            if (sw_trig_i) sw_pend_d = 1'b1;
            if (data_en_i && (sw_pend_q || sw_trig_i || edge_hit)) begin
               sw_pend_d   = 1'b0;
               trig_addr_d = wr_ptr_q;
               triggered_d = 1'b1;
               cnt_d       = '0;
               state_d     = (pretrig_q == c_pre_full) ? ST_DONE : ST_POST;
            end
         end
         ST_POST: begin
            if (data_en_i) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == c_post_span - pretrig_q) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (rd_fire) rd_valid_d = 1'b0;
            if (rd_fire && rd_last_q) begin
               state_d     = ST_IDLE;
               triggered_d = 1'b0;
               rd_last_d   = 1'b0;
            end else if ((!rd_valid_q || rd_fire) && rd_cnt_q != c_rd_all) begin
               // Issue the next read whenever the output word is free or being taken.
               ram_re     = 1'b1;
               rd_addr_d  = rd_addr_q + 1'b1;
               rd_cnt_d   = rd_cnt_q + 1'b1;
               rd_valid_d = 1'b1;
               rd_last_d  = (rd_cnt_q == c_rd_last);
            end
         end
         default: ;
      endcase

      if (state_d == ST_DONE && state_q != ST_DONE) begin
         rd_addr_d  = trig_addr_d - pretrig_q;
         rd_cnt_d   = '0;
         rd_valid_d = 1'b0;
         rd_last_d  = 1'b0;
      end

      // Arming from DONE abandons the replay; a same-cycle sw trigger is dropped.
      if (arm_i && (state_q == ST_IDLE || state_q == ST_DONE)) begin
         pretrig_d   = pretrig_i;
         level_d     = trig_level_i;
         falling_d   = trig_edge_i;
         cnt_d       = '0;
         prev_vld_d  = 1'b0;
         sw_pend_d   = 1'b0;
         triggered_d = 1'b0;
         rd_valid_d  = 1'b0;
         rd_last_d   = 1'b0;
         state_d     = (pretrig_i == '0) ? ST_WAIT_TRIG : ST_PRE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         cnt_q       <= '0;
         pretrig_q   <= '0;
         level_q     <= '0;
         falling_q   <= 1'b0;
         prev_q      <= '0;
         prev_vld_q  <= 1'b0;
         sw_pend_q   <= 1'b0;
         trig_addr_q <= '0;
         triggered_q <= 1'b0;
         rd_addr_q   <= '0;
         rd_cnt_q    <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         pretrig_q   <= pretrig_d;
         level_q     <= level_d;
         falling_q   <= falling_d;
         prev_q      <= prev_d;
         prev_vld_q  <= prev_vld_d;
         sw_pend_q   <= sw_pend_d;
         trig_addr_q <= trig_addr_d;
         triggered_q <= triggered_d;
         rd_addr_q   <= rd_addr_d;
         rd_cnt_q    <= rd_cnt_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
      end
   end

   capture_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (DEPTH_LOG2)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_i),
      .re_i    (ram_re),
      .raddr_i (rd_addr_q),
      .rdata_o (ram_rdata)
   );

   assign busy_o      = (state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
   assign done_o      = (state_q == ST_DONE);
   assign triggered_o = triggered_q;
   assign trig_addr_o = trig_addr_q;
   assign rd_valid_o  = rd_valid_q;
   // The RAM has no reset, so the data port is forced to zero when not valid.
   assign rd_data_o   = rd_valid_q ? ram_rdata : '0;
   assign rd_last_o   = rd_last_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_stream_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_adc_stream_capture : scoreboard bench for the triggered capture buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_adc_stream_capture;
   localparam int DW    = 14;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          data_en_i = 1'b0;
   logic [DW-1:0] data_i = '0;
   logic          arm_i = 1'b0;
   logic          sw_trig_i = 1'b0;
   logic [DW-1:0] trig_level_i = '0;
   logic          trig_edge_i = 1'b0;
   logic [AW-1:0] pretrig_i = '0;
   logic          busy_o, triggered_o, done_o, rd_valid_o, rd_last_o;
   logic          rd_ready_i = 1'b0;
   logic [AW-1:0] trig_addr_o;
   logic [DW-1:0] rd_data_o;

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [DW-1:0] acc_q[$];
   logic [DW-1:0] exp_q[$];
   int            wp_model = 0;
   int            wp_arm   = 0;
   int            pre_cfg  = 0;

   adc_stream_capture #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .data_en_i    (data_en_i),
      .data_i       (data_i),
      .arm_i        (arm_i),
      .sw_trig_i    (sw_trig_i),
      .trig_level_i (trig_level_i),
      .trig_edge_i  (trig_edge_i),
      .pretrig_i    (pretrig_i),
      .busy_o       (busy_o),
      .triggered_o  (triggered_o),
      .done_o       (done_o),
      .trig_addr_o  (trig_addr_o),
      .rd_valid_o   (rd_valid_o),
      .rd_ready_i   (rd_ready_i),
      .rd_data_o    (rd_data_o),
      .rd_last_o    (rd_last_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_arm(input int pre, input int lvl, input bit fall, input bit sw);
      pretrig_i    = AW'(pre);
      trig_level_i = DW'(lvl);
      trig_edge_i  = fall;
      arm_i        = 1'b1;
      sw_trig_i    = sw;
      data_en_i    = 1'b0;
      tick();
      arm_i     = 1'b0;
      sw_trig_i = 1'b0;
      acc_q.delete();
      exp_q.delete();
      pre_cfg = pre;
      wp_arm  = wp_model;
   endtask

   task automatic put(input bit en, input int val, input bit sw);
      data_en_i = en;
      data_i    = DW'(val);
      sw_trig_i = sw;
      tick();
      if (en) begin
         acc_q.push_back(DW'(val));
         wp_model = (wp_model + 1) % DEPTH;
      end
      data_en_i = 1'b0;
      sw_trig_i = 1'b0;
   endtask

   // Checks the end-of-capture status and queues the expected replay window.
   task automatic close_capture(input string name, input int tidx);
      int need;
      int base;
      need = tidx + DEPTH - pre_cfg;
      base = tidx - pre_cfg;
      n_checks++;
      if (acc_q.size() != need)
         $display("FAIL %s accepted_count: got %0d want %0d", name, acc_q.size(), need);
      else n_pass++;
      n_checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0)
         $display("FAIL %s done_state: done=%b busy=%b want done=1 busy=0", name, done_o, busy_o);
      else n_pass++;
      n_checks++;
      if (triggered_o !== 1'b1)
         $display("FAIL %s triggered: got %b want 1", name, triggered_o);
      else n_pass++;
      n_checks++;
      if (trig_addr_o !== AW'((wp_arm + tidx) % DEPTH))
         $display("FAIL %s trig_addr: got %0d want %0d", name, trig_addr_o, (wp_arm + tidx) % DEPTH);
      else n_pass++;
      for (int j = 0; j < DEPTH; j++)
         if (base + j >= 0 && base + j < acc_q.size()) exp_q.push_back(acc_q[base + j]);
   endtask

   task automatic drain(input string name, input int max_hs, input bit toggle);
      int            hs, cyc, lat;
      bit            held;
      logic [DW-1:0] hd, e;
      logic          hl;
      hs = 0; cyc = 0; lat = 0; held = 0; hd = '0; hl = 1'b0;
      while (rd_valid_o !== 1'b1 && lat < 2) begin
         tick();
         lat++;
      end
      n_checks++;
      if (rd_valid_o !== 1'b1)
         $display("FAIL %s rd_valid_latency: valid=%b after %0d cycles want 1", name, rd_valid_o, lat);
      else n_pass++;
      while (hs < max_hs && cyc < 200) begin
         rd_ready_i = toggle ? ((cyc % 2) == 1) : 1'b1;
         if (held) begin
            n_checks++;
            if (rd_valid_o !== 1'b1 || rd_data_o !== hd || rd_last_o !== hl)
               $display("FAIL %s rd_hold: valid=%b data=%0d last=%b want 1/%0d/%b",
                        name, rd_valid_o, $signed(rd_data_o), rd_last_o, $signed(hd), hl);
            else n_pass++;
         end
         held = (rd_valid_o === 1'b1) && !rd_ready_i;
         hd   = rd_data_o;
         hl   = rd_last_o;
         if (rd_valid_o === 1'b1 && rd_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL %s rd_extra: got sample %0d want none", name, $signed(rd_data_o));
            end else begin
               e = exp_q.pop_front();
               if (rd_data_o !== e)
                  $display("FAIL %s rd_data[%0d]: got %0d want %0d", name, hs, $signed(rd_data_o), $signed(e));
               else n_pass++;
               n_checks++;
               if (rd_last_o !== (exp_q.size() == 0))
                  $display("FAIL %s rd_last[%0d]: got %b want %b", name, hs, rd_last_o, exp_q.size() == 0);
               else n_pass++;
            end
            hs++;
         end else if (!toggle) begin
            n_checks++;
            $display("FAIL %s rd_rate: valid=%b at cycle %0d want 1", name, rd_valid_o, cyc);
         end
         tick();
         cyc++;
      end
      rd_ready_i = 1'b0;
      n_checks++;
      if (hs != max_hs) $display("FAIL %s handshakes: got %0d want %0d", name, hs, max_hs);
      else n_pass++;
      if (max_hs == DEPTH) begin
         n_checks++;
         if (done_o !== 1'b0 || triggered_o !== 1'b0 || rd_valid_o !== 1'b0)
            $display("FAIL %s after_readout: done=%b trig=%b valid=%b want 0/0/0",
                     name, done_o, triggered_o, rd_valid_o);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      #2 rst_i = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({busy_o, triggered_o, done_o, trig_addr_o, rd_valid_o, rd_data_o, rd_last_o} !== '0)
         $display("FAIL reset_outputs: busy=%b trig=%b done=%b addr=%0d valid=%b data=%0d last=%b want all 0",
                  busy_o, triggered_o, done_o, trig_addr_o, rd_valid_o, rd_data_o, rd_last_o);
      else n_pass++;
      rst_i = 1'b0;
      wp_model = 0;
      tick();
      tick();
      n_checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0)
         $display("FAIL reset_idle: busy=%b done=%b want 0/0", busy_o, done_o);
      else n_pass++;
   endtask

   task automatic test_rising(input string name);
      do_arm(4, 100, 1'b0, 1'b0);
      n_checks++;
      if (busy_o !== 1'b1) $display("FAIL %s busy_after_arm: got %b want 1", name, busy_o);
      else n_pass++;
      for (int i = 0; i < 64 && done_o !== 1'b1; i++) put(1'b1, 10 * i, 1'b0);
      close_capture(name, 10);
      drain(name, DEPTH, 1'b0);
   endtask

   task automatic test_falling();
      do_arm(0, -50, 1'b1, 1'b1);
      for (int i = 0; i < 64 && done_o !== 1'b1; i++) put(1'b1, -20 * i, 1'b0);
      close_capture("falling", 3);
      drain("falling", DEPTH, 1'b0);
   endtask

   task automatic test_edge_in_pre();
      int seq[12] = '{-10, -5, 5, 7, -3, -4, -6, -7, -8, -9, -2, 20};
      do_arm(8, 0, 1'b0, 1'b0);
      for (int i = 0; i < 64 && done_o !== 1'b1; i++) put(1'b1, (i < 12) ? seq[i] : 20 + i, 1'b0);
      close_capture("edge_pre", 11);
      drain("edge_pre", DEPTH, 1'b0);
   endtask

   task automatic test_gaps_backpressure();
      do_arm(2, 100, 1'b0, 1'b0);
      for (int k = 0; k < 128 && done_o !== 1'b1; k++)
         put((k % 4 == 0) || (k % 4 == 3), 10 * k, 1'b0);
      close_capture("gaps", 5);
      drain("gaps", DEPTH, 1'b1);
   endtask

   task automatic test_abort_rearm();
      do_arm(4, 100, 1'b0, 1'b0);
      for (int i = 0; i < 64 && done_o !== 1'b1; i++) put(1'b1, 10 * i, 1'b0);
      close_capture("abort_first", 10);
      drain("abort_first", 3, 1'b0);
      do_arm(0, 0, 1'b0, 1'b0);
      n_checks++;
      if (rd_valid_o !== 1'b0 || done_o !== 1'b0 || triggered_o !== 1'b0 || busy_o !== 1'b1)
         $display("FAIL abort_state: valid=%b done=%b trig=%b busy=%b want 0/0/0/1",
                  rd_valid_o, done_o, triggered_o, busy_o);
      else n_pass++;
      for (int i = 0; i < 64 && done_o !== 1'b1; i++) put(1'b1, 500 + i, i == 0);
      close_capture("abort_rearm", 0);
      drain("abort_rearm", DEPTH, 1'b0);
   endtask

   task automatic test_sw_full_pretrig();
      do_arm(15, 8000, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) put(1'b1, i + 1, 1'b0);
      put(1'b0, 7777, 1'b1);
      put(1'b0, 7777, 1'b0);
      put(1'b0, 7777, 1'b0);
      n_checks++;
      if (busy_o !== 1'b1 || triggered_o !== 1'b0)
         $display("FAIL sw_pending: busy=%b trig=%b want 1/0", busy_o, triggered_o);
      else n_pass++;
      put(1'b1, 99, 1'b0);
      close_capture("sw_full", 18);
      drain("sw_full", DEPTH, 1'b0);
   endtask

   task automatic test_reset_mid_capture();
      do_arm(4, 100, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) put(1'b1, 10 * i, 1'b0);
      n_checks++;
      if (triggered_o !== 1'b1 || busy_o !== 1'b1)
         $display("FAIL rst_mid_post: trig=%b busy=%b want 1/1", triggered_o, busy_o);
      else n_pass++;
      #2 rst_i = 1'b1;
      #1;
      n_checks++;
      if ({busy_o, triggered_o, done_o, trig_addr_o, rd_valid_o, rd_data_o, rd_last_o} !== '0)
         $display("FAIL rst_mid_outputs: busy=%b trig=%b done=%b addr=%0d valid=%b want all 0",
                  busy_o, triggered_o, done_o, trig_addr_o, rd_valid_o);
      else n_pass++;
      tick();
      tick();
      rst_i = 1'b0;
      wp_model = 0;
      tick();
      test_rising("rst_rerun");
   endtask

   initial begin
      test_reset();
      test_rising("rising");
      test_falling();
      test_edge_in_pre();
      test_gaps_backpressure();
      test_abort_rearm();
      test_sw_full_pretrig();
      test_reset_mid_capture();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
